// File: rtl/halli_galli_core.sv
// Halli Galli referee core: deals face-up cards, judges bell rings, keeps scores and ends the game.
// Optional feature: define HG_PENALTY_EN to charge one point for a wrong ring.
module halli_galli_core #(
   parameter int unsigned PLAYERS     = 2,
   parameter int unsigned DECK_SIZE   = 56,
   parameter int unsigned SCORE_W     = 8,
   parameter int unsigned BELL_SUM    = 5,
   parameter int unsigned LAST_WINDOW = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flip,
   input  logic [4:0]                    card_in,
   input  logic [PLAYERS-1:0]            bell,
   output logic [$clog2(PLAYERS)-1:0]    turn,
   output logic [PLAYERS*5-1:0]          top_cards,
   output logic [PLAYERS*SCORE_W-1:0]    score,
   output logic                          bell_ok,
   output logic                          ring_valid,
   output logic [$clog2(PLAYERS)-1:0]    ring_who,
   output logic                          ring_right,
   output logic                          done,
   output logic [$clog2(PLAYERS)-1:0]    winner,
   output logic                          tie
);

   localparam int unsigned IDX_W   = $clog2(PLAYERS);
   localparam int unsigned DEALT_W = $clog2(DECK_SIZE + 1);
   localparam int unsigned WIN_W   = $clog2(LAST_WINDOW + 1);
   localparam int unsigned SUM_W   = $clog2(PLAYERS * 5 + 1);
   localparam int unsigned ADD_W   = ((SCORE_W > DEALT_W) ? SCORE_W : DEALT_W) + 1;
   localparam logic [ADD_W-1:0] SCORE_MAX = ADD_W'({SCORE_W{1'b1}});

   typedef enum logic [1:0] {StPlay, StResolve, StWindow, StDone} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     turn_q, turn_d;
   logic [4:0]           top_q [PLAYERS];
   logic [4:0]           top_d [PLAYERS];
   logic [SCORE_W-1:0]   score_q [PLAYERS];
   logic [SCORE_W-1:0]   score_d [PLAYERS];
   logic [DEALT_W-1:0]   pile_q, pile_d;
   logic [DEALT_W-1:0]   dealt_q, dealt_d;
   logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
   logic [IDX_W-1:0]     ring_who_q, ring_who_d;
   logic [PLAYERS-1:0]   bell_q;
   logic                 bell_ok_q;

   logic [PLAYERS-1:0]   press;
   logic                 any_press;
   logic [IDX_W-1:0]     press_idx;
   logic                 ring_cond;
   logic [SUM_W-1:0]     col_sum;
   logic                 card_valid;
   logic [ADD_W-1:0]     add_sum;
   logic [SCORE_W-1:0]   best;
   logic [IDX_W-1:0]     win_idx;
   int unsigned          n_best;

   assign press      = bell & ~bell_q;
   assign any_press  = |press;
   assign card_valid = (card_in[2:0] >= 3'd1) && (card_in[2:0] <= 3'd5);

   // Lowest pressing index wins a simultaneous ring.
   always_comb begin
      press_idx = '0;
      for (int i = PLAYERS - 1; i >= 0; i--) begin
         if (press[i]) press_idx = IDX_W'(i);
      end
   end

   always_comb begin
      ring_cond = 1'b0;
      col_sum   = '0;
      for (int c = 0; c < 4; c++) begin
         col_sum = '0;
         for (int i = 0; i < PLAYERS; i++) begin
            if (top_q[i] != 5'd0 && top_q[i][4:3] == 2'(c)) begin
               col_sum = col_sum + SUM_W'(top_q[i][2:0]);
            end
         end
         if (col_sum == SUM_W'(BELL_SUM)) ring_cond = 1'b1;
      end
   end

   always_comb begin
      best    = score_q[0];
      win_idx = '0;
      n_best  = 0;
      for (int i = 1; i < PLAYERS; i++) begin
         if (score_q[i] > best) begin
            best    = score_q[i];
            win_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < PLAYERS; i++) begin
         if (score_q[i] == best) n_best = n_best + 1;
      end
   end

   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      top_d      = top_q;
      score_d    = score_q;
      pile_d     = pile_q;
      dealt_d    = dealt_q;
      win_cnt_d  = win_cnt_q;
      ring_who_d = ring_who_q;
      add_sum    = '0;
      unique case (state_q)
         StPlay: begin
            if (any_press) begin
               ring_who_d = press_idx;
               state_d    = StResolve;
            end else if (flip && card_valid) begin
               top_d[turn_q] = card_in;
               pile_d        = pile_q + DEALT_W'(1);
               dealt_d       = dealt_q + DEALT_W'(1);
               turn_d        = (turn_q == IDX_W'(PLAYERS - 1)) ? '0 : turn_q + IDX_W'(1);
               if (dealt_q == DEALT_W'(DECK_SIZE - 1)) begin
                  state_d   = StWindow;
                  win_cnt_d = WIN_W'(LAST_WINDOW);
               end
            end
         end
         StResolve: begin
            if (ring_cond) begin
               add_sum = ADD_W'(score_q[ring_who_q]) + ADD_W'(pile_q);
               score_d[ring_who_q] = (add_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                            : add_sum[SCORE_W-1:0];
               pile_d = '0;
               for (int i = 0; i < PLAYERS; i++) top_d[i] = 5'd0;
            end else begin
`ifdef HG_PENALTY_EN
               if (score_q[ring_who_q] != '0) begin
                  score_d[ring_who_q] = score_q[ring_who_q] - SCORE_W'(1);
               end
`else
               score_d = score_q;
`endif
            end
            if (dealt_q == DEALT_W'(DECK_SIZE)) begin
               if (ring_cond) begin
                  state_d = StDone;
               end else begin
                  state_d   = StWindow;
                  win_cnt_d = WIN_W'(LAST_WINDOW);
               end
            end else begin
               state_d = StPlay;
            end
         end
         StWindow: begin
            if (any_press) begin
               ring_who_d = press_idx;
               state_d    = StResolve;
            end else if (win_cnt_q <= WIN_W'(1)) begin
               win_cnt_d = '0;
               state_d   = StDone;
            end else begin
               win_cnt_d = win_cnt_q - WIN_W'(1);
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: state_d = StPlay;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StPlay;
         turn_q     <= '0;
         top_q      <= '{default: '0};
         score_q    <= '{default: '0};
         pile_q     <= '0;
         dealt_q    <= '0;
         win_cnt_q  <= '0;
         ring_who_q <= '0;
         bell_q     <= '0;
         bell_ok_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         top_q      <= top_d;
         score_q    <= score_d;
         pile_q     <= pile_d;
         dealt_q    <= dealt_d;
         win_cnt_q  <= win_cnt_d;
         ring_who_q <= ring_who_d;
         bell_q     <= bell;
         bell_ok_q  <= ring_cond;
      end
   end

   always_comb begin
      top_cards = '0;
      score     = '0;
      for (int i = 0; i < PLAYERS; i++) begin
         top_cards[5*i +: 5]           = top_q[i];
         score[SCORE_W*i +: SCORE_W]   = score_q[i];
      end
   end

   assign turn       = turn_q;
   assign bell_ok    = bell_ok_q;
   assign ring_valid = (state_q == StResolve);
   assign ring_right = ring_valid & ring_cond;
   assign ring_who   = ring_who_q;
   assign done       = (state_q == StDone);
   assign winner     = done ? win_idx : '0;
   assign tie        = done & (n_best > 1);

endmodule

// File: tb/tb_halli_galli_core.sv
// Scoreboard bench for halli_galli_core: ring reports are queued at press time and
// matched when ring_valid appears; table/score/end-game state is checked directly.
module tb_halli_galli_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flip = 1'b0;
   logic [4:0]  card_in = '0;
   logic [1:0]  bell = '0;
   logic [0:0]  turn;
   logic [9:0]  top_cards;
   logic [15:0] score;
   logic        bell_ok;
   logic        ring_valid;
   logic [0:0]  ring_who;
   logic        ring_right;
   logic        done;
   logic [0:0]  winner;
   logic        tie;

   int n_cmp = 0;
   int n_err = 0;
   logic [1:0] sb_q [$];   // {who, right}

   halli_galli_core #(
      .PLAYERS(2), .DECK_SIZE(4), .SCORE_W(8), .BELL_SUM(5), .LAST_WINDOW(8)
   ) dut (
      .clk(clk), .rst(rst), .flip(flip), .card_in(card_in), .bell(bell),
      .turn(turn), .top_cards(top_cards), .score(score), .bell_ok(bell_ok),
      .ring_valid(ring_valid), .ring_who(ring_who), .ring_right(ring_right),
      .done(done), .winner(winner), .tie(tie)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ring_valid) begin
         if (sb_q.size() == 0) begin
            check_val("ring_unexpected", 32'd1, 32'd0);
         end else begin
            logic [1:0] e;
            e = sb_q.pop_front();
            check_val("ring_who", 32'(ring_who), 32'(e[1]));
            check_val("ring_right", 32'(ring_right), 32'(e[0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flip = 1'b0; bell = '0; card_in = '0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic do_flip(input logic [4:0] c);
      flip = 1'b1; card_in = c;
      cyc();
      flip = 1'b0;
   endtask

   task automatic do_press(input logic [1:0] mask, input logic who, input logic right);
      sb_q.push_back({who, right});
      bell = mask;
      cyc();
      cyc();
      bell = '0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      check_val("rst_turn", 32'(turn), 0);
      check_val("rst_top", 32'(top_cards), 0);
      check_val("rst_score", 32'(score), 0);
      check_val("rst_bell_ok", 32'(bell_ok), 0);
      check_val("rst_ring_valid", 32'(ring_valid), 0);
      check_val("rst_ring_who", 32'(ring_who), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_winner_tie", 32'({winner, tie}), 0);

      // Correct ring by player 1: red/2 + red/3
      do_flip(5'd2);
      check_val("t1_turn1", 32'(turn), 1);
      do_flip(5'd3);
      check_val("t1_top", 32'(top_cards), 32'({5'd3, 5'd2}));
      check_val("t1_turn0", 32'(turn), 0);
      cyc();
      check_val("t1_bell_ok", 32'(bell_ok), 1);
      do_press(2'b10, 1'b1, 1'b1);
      check_val("t1_score", 32'(score), 32'({8'd2, 8'd0}));
      check_val("t1_top_clr", 32'(top_cards), 0);
      cyc();
      check_val("t1_bell_ok_clr", 32'(bell_ok), 0);

      // Wrong ring: red/2 + green/3
      do_reset();
      do_flip(5'd2);
      do_flip(5'd11);
      cyc();
      check_val("t2_bell_ok", 32'(bell_ok), 0);
      do_press(2'b01, 1'b0, 1'b0);
      check_val("t2_score", 32'(score), 0);
      check_val("t2_top", 32'(top_cards), 32'({5'd11, 5'd2}));

      // Simultaneous presses on a correct table
      do_reset();
      do_flip(5'd2);
      do_flip(5'd3);
      do_press(2'b11, 1'b0, 1'b1);
      check_val("t3_score", 32'(score), 32'({8'd0, 8'd2}));

      // Flip + press in one cycle, and invalid numbers
      do_reset();
      do_flip(5'd1);
      sb_q.push_back({1'b1, 1'b0});
      flip = 1'b1; card_in = 5'd4; bell = 2'b10;
      cyc();
      flip = 1'b0;
      cyc();
      bell = '0;
      cyc();
      check_val("t4_top", 32'(top_cards), 32'd1);
      check_val("t4_turn", 32'(turn), 1);
      do_flip(5'd6);
      do_flip(5'd8);
      check_val("t4_bad_top", 32'(top_cards), 32'd1);
      check_val("t4_bad_turn", 32'(turn), 1);

      // Deal out with no ring, window expires -> tie
      do_reset();
      do_flip(5'd1);
      do_flip(5'd9);
      do_flip(5'd2);
      do_flip(5'd10);
      do_flip(5'd3);   // ignored in the window; consumes one of the 8 cycles
      check_val("t5_win_top", 32'(top_cards), 32'({5'd10, 5'd2}));
      check_val("t5_not_done", 32'(done), 0);
      repeat (7) cyc();
      check_val("t5_done", 32'(done), 1);
      check_val("t5_tie", 32'(tie), 1);
      check_val("t5_winner", 32'(winner), 0);

      // Correct ring in the window on the last deal -> player 1 wins outright
      do_reset();
      do_flip(5'd9);
      do_flip(5'd9);
      do_flip(5'd2);
      do_flip(5'd3);
      do_press(2'b10, 1'b1, 1'b1);
      check_val("t6_score", 32'(score), 32'({8'd4, 8'd0}));
      check_val("t6_done", 32'(done), 1);
      check_val("t6_winner", 32'(winner), 1);
      check_val("t6_tie", 32'(tie), 0);

      // Reset during the window
      do_reset();
      do_flip(5'd9);
      do_flip(5'd1);
      do_flip(5'd10);
      do_flip(5'd2);
      repeat (3) cyc();
      rst = 1'b1;
      #1;
      check_val("t7_rst_outs", 32'({done, turn, bell_ok, ring_valid, tie, winner}), 0);
      check_val("t7_rst_top", 32'(top_cards), 0);
      cyc();
      rst = 1'b0;
      cyc();
      do_flip(5'd3);
      check_val("t7_play_top", 32'(top_cards), 32'd3);
      check_val("t7_play_done", 32'(done), 0);

      // Reset during RESOLVE aborts the score update
      do_reset();
      do_flip(5'd2);
      do_flip(5'd3);
      bell = 2'b01;
      cyc();
      check_val("t8_in_resolve", 32'(ring_valid), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bell = '0;
      cyc();
      check_val("t8_score", 32'(score), 0);
      check_val("t8_top", 32'(top_cards), 0);

      check_val("sb_empty", 32'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/halli_galli_core.md
HALLI_GALLI_CORE -- requirements
Module: halli_galli_core

Interface
REQ-001 SHALL provide parameter PLAYERS, default 2, number of players (2..4).
REQ-002 SHALL provide parameter DECK_SIZE, default 56, cards dealt per game.
REQ-003 SHALL provide parameter SCORE_W, default 8, per-player score width.
REQ-004 SHALL provide parameter BELL_SUM, default 5, colour sum that makes a ring correct.
REQ-005 SHALL provide parameter LAST_WINDOW, default 1000, ring window in cycles after the last card.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 flip  in  1  single-cycle pulse: current player turns a card.
REQ-009 card_in  in  5  {color[4:3], number[2:0]}; sampled with flip.
REQ-010 bell  in  PLAYERS  level per player from the key scanner, bit i = player i.
REQ-011 turn  out  clog2(PLAYERS)  index of the player to flip next.
REQ-012 top_cards  out  PLAYERS*5  face-up card per player, player i at [5i+4:5i]; 0 = none.
REQ-013 score  out  PLAYERS*SCORE_W  per-player score, player i at [SCORE_W*(i+1)-1:SCORE_W*i].
REQ-014 bell_ok  out  1  registered: current table satisfies the ring condition.
REQ-015 ring_valid / ring_who / ring_right  out  1 / clog2(PLAYERS) / 1  one-cycle ring resolution report.
REQ-016 done / winner / tie  out  1 / clog2(PLAYERS) / 1  game-over flag, winning index, draw flag.

Function
REQ-017 SHALL edge-detect bell: press[i] = bell[i] & ~bell_q[i].
REQ-018 FSM states: PLAY, RESOLVE, WINDOW, DONE.
REQ-019 PLAY, flip with number 1..5: top_cards[turn] <= card_in, pile +1, dealt +1, turn <= (turn+1) mod PLAYERS.
REQ-020 PLAY, flip with number 0 or 6..7: card ignored; no counter or turn change.
REQ-021 PLAY or WINDOW, any press bit: latch ring_who = lowest set press index and go to RESOLVE; a flip in the same cycle is ignored.
REQ-022 Ring condition: for some colour c, the sum of numbers of non-empty top cards with colour c equals BELL_SUM; the sum width is clog2(PLAYERS*5+1).
REQ-023 RESOLVE, one cycle: ring_valid=1, ring_right=condition.
REQ-024 Correct ring: score[ring_who] += pile, saturating at 2^SCORE_W-1; pile <= 0; all top_cards <= 0.
REQ-025 Wrong ring: behaviour is per REQ-035/036; top cards and pile unchanged.
REQ-026 RESOLVE exit: to DONE if dealt==DECK_SIZE and the ring was correct; to WINDOW if dealt==DECK_SIZE and the ring was wrong; else to PLAY.
REQ-027 A flip that makes dealt==DECK_SIZE SHALL move PLAY->WINDOW and load the window counter with LAST_WINDOW.
REQ-028 WINDOW: flips ignored; counter decrements each cycle; counter reaching 0 with no press -> DONE. Re-entry from RESOLVE reloads the counter.
REQ-029 DONE: done=1; winner = lowest index holding the maximum score; tie=1 if two or more players hold it. State held until rst.
REQ-030 bell_ok SHALL update one cycle after any top_cards change.
REQ-031 Presses in RESOLVE or DONE SHALL be ignored; bell_q still tracks.

Reset
REQ-032 On rst: state=PLAY, turn=0, all top_cards=0, scores=0, pile=0, dealt=0, window counter=0.
REQ-033 On rst: bell_q=0, and bell_ok, ring_valid, ring_who, ring_right, done, winner and tie all 0.
REQ-034 rst mid-RESOLVE or mid-WINDOW SHALL abort with no score update.

Configuration
REQ-035 With HG_PENALTY_EN defined: a wrong ring decrements score[ring_who] by 1, saturating at 0.
REQ-036 Without HG_PENALTY_EN: a wrong ring leaves all scores unchanged; only the ring_right=0 report occurs.

Verification (PLAYERS=2, BELL_SUM=5, DECK_SIZE=4, LAST_WINDOW=8)
REQ-037 Flip red/2 then red/3, player 1 presses -> bell_ok=1; ring_valid with ring_who=1, ring_right=1; score1=2; top_cards=0; pile=0.
REQ-038 Flip red/2 then green/3, player 0 presses -> ring_right=0; score0=0 in both builds (penalty saturates at 0); top cards unchanged.
REQ-039 Both players' bell rise in the same cycle on a correct table -> ring_who=0; only score0 increments.
REQ-040 A flip and a press in the same cycle -> the card is not dealt and turn is unchanged.
REQ-041 Deal 4 cards with no ring, then 8 idle cycles -> done=1; scores equal -> tie=1, winner=0.
REQ-042 Assert rst during WINDOW -> all outputs 0, state PLAY on the next cycle.
